// File: rtl/brc_resolve.sv
// rtl/brc_resolve.sv - branch compare, target, mispredict check and perf counters
//
// Purpose: resolves one B-type branch per accepted op into a registered
// valid/ready result slot and keeps saturating transfer/mispredict counters.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_valid / o_ready       upstream handshake (o_ready = !o_valid | i_ready)
//   i_funct3, i_rs1_data, i_rs2_data, i_pc, i_imm, i_pred_taken   branch op
//   i_flush                 kill held and incoming op
//   o_valid / i_ready       downstream handshake for the result
//   o_taken, o_equal, o_less, o_target, o_mispredict, o_illegal   result
//   i_cnt_clr, o_br_cnt, o_mis_cnt   statistics counters
module brc_resolve #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_rs1_data,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_imm,
  input  logic             i_pred_taken,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_taken,
  output logic             o_equal,
  output logic             o_less,
  output logic [XLEN-1:0]  o_target,
  output logic             o_mispredict,
  output logic             o_illegal,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_mis_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             valid_q, valid_d;
  logic             taken_q, equal_q, less_q, mis_q, illegal_q;
  logic [XLEN-1:0]  target_q;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  logic             equal_d, less_d, taken_d, illegal_d, mis_d;
  logic             less_u, less_s;
  logic [XLEN:0]    diff;
  logic [XLEN-1:0]  target_d;
  logic             accept, xfer;

  assign o_ready = !valid_q | i_ready;
  assign accept  = i_valid & o_ready & !i_flush;
  assign xfer    = valid_q & i_ready;

  // Borrow out of the widened subtract gives unsigned less-than; for signed,
  // differing MSBs decide directly, otherwise the unsigned result holds.
  assign diff     = {1'b0, i_rs1_data} - {1'b0, i_rs2_data};
  assign less_u   = diff[XLEN];
  assign less_s   = (i_rs1_data[XLEN-1] != i_rs2_data[XLEN-1]) ? i_rs1_data[XLEN-1] : less_u;
  assign equal_d  = (i_rs1_data == i_rs2_data);
  assign less_d   = i_funct3[1] ? less_u : less_s;
  assign target_d = i_pc + i_imm;

  always_comb begin
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    case (i_funct3)
      3'b000:  taken_d = equal_d;
      3'b001:  taken_d = !equal_d;
      3'b100:  taken_d = less_d;
      3'b101:  taken_d = !less_d;
      3'b110:  taken_d = less_d;
      3'b111:  taken_d = !less_d;
      default: illegal_d = 1'b1;
    endcase
  end

  assign mis_d = taken_d != i_pred_taken;

  always_comb begin
    valid_d = valid_q;
    if (i_flush)     valid_d = 1'b0;
    else if (accept) valid_d = 1'b1;
    else if (xfer)   valid_d = 1'b0;

    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (i_cnt_clr) begin
      br_cnt_d  = '0;
      mis_cnt_d = '0;
    end else if (xfer) begin
      if (br_cnt_q != CNT_MAX) br_cnt_d = br_cnt_q + 1'b1;
      if (mis_q && mis_cnt_q != CNT_MAX) mis_cnt_d = mis_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      equal_q   <= 1'b0;
      less_q    <= 1'b0;
      mis_q     <= 1'b0;
      illegal_q <= 1'b0;
      target_q  <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      // Result fields only move on accept, so a held result stays stable.
      if (accept) begin
        taken_q   <= taken_d;
        equal_q   <= equal_d;
        less_q    <= less_d;
        mis_q     <= mis_d;
        illegal_q <= illegal_d;
        target_q  <= target_d;
      end
    end
  end

  assign o_valid      = valid_q;
  assign o_taken      = taken_q;
  assign o_equal      = equal_q;
  assign o_less       = less_q;
  assign o_target     = target_q;
  assign o_mispredict = mis_q;
  assign o_illegal    = illegal_q;
  assign o_br_cnt     = br_cnt_q;
  assign o_mis_cnt    = mis_cnt_q;

endmodule
